vec_reduce_xcel: RTL and testbench
==================================

# vec_reduce_xcel

Parametrised vector-reduction accelerator: the next generation of the accumulate accelerator, with control and datapath in one block. On a `go` it streams `size` words from memory starting at `base_addr`, one outstanding request at a time over a val/rdy request port and a val-only response port. It folds the words into a result register using one of four reduction modes and pulses `done`. It sits between the processor's accelerator interface and a single-ported data memory.

## Interface

Parameters:
- `p_data_nbits`, 32, data word and result width
- `p_addr_nbits`, 16, byte-address width; addresses wrap modulo 2^p_addr_nbits
- `p_size_nbits`, 14, width of the element count

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `go`  in  1  start request; sampled only in IDLE
- `size`  in  p_size_nbits  element count, latched on accepted `go`
- `base_addr`  in  p_addr_nbits  byte address of element 0, latched on accepted `go`
- `mode`  in  2  0=SUM, 1=MAX (signed), 2=MIN (signed), 3=XOR; latched on accepted `go`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse in the DONE state
- `result`  out  p_data_nbits  reduction result; holds its value until the next accepted `go`
- `memreq_val`  out  1  request valid
- `memreq_rdy`  in  1  memory accepts the request
- `memreq_addr`  out  p_addr_nbits  request byte address
- `memresp_val`  in  1  response valid
- `memresp_data`  in  p_data_nbits  response word

## Operation

- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On `go`: latch `size`, `base_addr` and `mode`.
  - Set `addr` = `base_addr`, `count` = 0, and `result` = the identity for the mode: 0 for SUM/XOR, the most-negative signed value for MAX, the most-positive signed value for MIN.
  - Go to DONE if the latched size is 0, otherwise to REQ.
- REQ:
  - Drive `memreq_val`=1 with `memreq_addr`=`addr`.
  - When `memreq_rdy`=1, go to WAIT; otherwise stay in REQ with the address stable.
- WAIT:
  - When `memresp_val`=1, set `result` ← op(`result`, `memresp_data`), `addr` ← `addr`+4 (wrapping), `count` ← `count`+1.
  - Then go to DONE if `count`+1 equals the latched size, otherwise to REQ.
  - Without `memresp_val`, stay in WAIT.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Arithmetic:
  - SUM wraps modulo 2^p_data_nbits.
  - MAX and MIN compare two's-complement; on a tie `result` keeps its value.
  - XOR is bitwise.
- `go` is ignored outside IDLE, and the latched operands do not change mid-operation.
- `memresp_val` is ignored outside WAIT; it does not change `result` or `count`.
- `memreq_val` is 0 in every state except REQ.
- `count` compares at the full p_size_nbits width; the maximum size is 2^p_size_nbits−1.

## Timing

- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `memreq_val`=0, `memreq_addr`=0. Internal `addr`, `count` and the latched operands are 0.
- Reset asserted in any state aborts the operation on the next edge. The outstanding response is discarded because the FSM is no longer in WAIT.
- Cycle numbering: `go` is sampled at edge 0.
  - Cycle 1 is REQ for element 0.
  - With `memreq_rdy` always 1 and each response one cycle after acceptance, element i occupies REQ at cycle 2i+1 and WAIT at cycle 2i+2.
  - `done` rises at cycle 2N+1 and IDLE is re-entered at cycle 2N+2.
  - Each stall cycle on `memreq_rdy` or `memresp_val` adds one cycle.
- Size 0: `done` at cycle 1, `result` = the mode identity.
- The final `result` is visible in the DONE cycle and stays stable until the edge after the next accepted `go`.
- A new `go` held high in the DONE cycle is ignored. It is accepted in the following IDLE cycle.

## Structure

- Shared package `vec_reduce_pkg`:
  - `mode_t` enum (SUM, MAX, MIN, XOR).
  - `state_t` enum (IDLE, REQ, WAIT, DONE).
  - Address stride constant `c_word_bytes` = 4.
- One combinational sub-module `vec_reduce_alu`, parametrised by `p_data_nbits`. Inputs are `mode`, `a`, `b`; output is `out`. It implements the four operations.
- The identity-value selection also belongs in this sub-module, exposed as an output that depends only on `mode`.
- FSM, address register, count register and operand latches live in the top module using the existing register and adder library cells.

## Test plan

- SUM, base=0x0100, size=4, memory {1,2,3,4}, `memreq_rdy`=1, one-cycle response → addresses 0x100, 0x104, 0x108, 0x10C; `result`=10; `done` at cycle 9.
- MAX and MIN over {5, −3, 0x7FFF_FFFF, −0x8000_0000} (32-bit) → MAX=0x7FFF_FFFF, MIN=0x8000_0000; XOR over {0xF0F0, 0x0FF0} → 0xFF00.
- Size 0 in each mode → `done` at cycle 1, no `memreq_val`, `result`=identity (0, 0x8000_0000, 0x7FFF_FFFF, 0).
- Backpressure: `memreq_rdy` low for 3 cycles per request and responses delayed 2 cycles, size=2 → `memreq_addr` stable while stalled; spurious `memresp_val` during REQ ignored; `result` correct.
- Wrap: SUM over {0xFFFF_FFFF, 2} → 1; base=0xFFFC, size=2 → second address 0x0000.
- `rst` pulsed mid-operation in WAIT → next cycle IDLE, `result`=0, `busy`=0; a new `go` with size=1 completes normally; `go` asserted while busy is ignored.

Source files
------------

// File: rtl/vec_reduce_pkg.sv
// Shared types and constants for the vector-reduction accelerator.
package vec_reduce_pkg;

    typedef enum logic [1:0] {
        SUM = 2'd0,
        MAX = 2'd1,
        MIN = 2'd2,
        XOR = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Byte stride between consecutive elements.
    localparam int c_word_bytes = 4;

endpackage

// File: rtl/vec_reduce_xcel_if.sv
// Memory-side bus: val/rdy request channel and val-only response channel.
interface vec_reduce_xcel_if #(
    parameter int p_addr_nbits = 16,
    parameter int p_data_nbits = 32
);
    logic                    memreq_val;
    logic                    memreq_rdy;
    logic [p_addr_nbits-1:0] memreq_addr;
    logic                    memresp_val;
    logic [p_data_nbits-1:0] memresp_data;

    // Accelerator side issues requests and consumes responses.
    modport master (
        output memreq_val,
        output memreq_addr,
        input  memreq_rdy,
        input  memresp_val,
        input  memresp_data
    );

    // Memory side accepts requests and returns data.
    modport slave (
        input  memreq_val,
        input  memreq_addr,
        output memreq_rdy,
        output memresp_val,
        output memresp_data
    );
endinterface

// File: rtl/vec_reduce_alu.sv
// Reduction operator and per-mode identity value (purely combinational).
module vec_reduce_alu
    import vec_reduce_pkg::*;
#(
    parameter int p_data_nbits = 32
) (
    input  mode_t                   mode,
    input  logic [p_data_nbits-1:0] a,
    input  logic [p_data_nbits-1:0] b,
    output logic [p_data_nbits-1:0] out,
    output logic [p_data_nbits-1:0] identity
);

    // Fold b into a; MAX/MIN keep a on a tie.
    always_comb begin
        out = a;
        case (mode)
            SUM: out = a + b;
            MAX: out = ($signed(b) > $signed(a)) ? b : a;
            MIN: out = ($signed(b) < $signed(a)) ? b : a;
            XOR: out = a ^ b;
            default: out = a;
        endcase
    end

    // Starting value that leaves the first element unchanged.
    always_comb begin
        identity = '0;
        case (mode)
            MAX: identity = {1'b1, {(p_data_nbits-1){1'b0}}};
            MIN: identity = {1'b0, {(p_data_nbits-1){1'b1}}};
            default: identity = '0;
        endcase
    end

endmodule

// File: rtl/vec_reduce_xcel.sv
// Vector-reduction accelerator: streams words from memory, one request
// outstanding at a time, and folds them into a result register.
//
//   state | meaning
//   IDLE  | waiting for go; operands latched on acceptance
//   REQ   | request for the current element presented to memory
//   WAIT  | request accepted, waiting for the response word
//   DONE  | one-cycle done pulse, result final
module vec_reduce_xcel
    import vec_reduce_pkg::*;
#(
    parameter int p_data_nbits = 32,
    parameter int p_addr_nbits = 16,
    parameter int p_size_nbits = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [p_size_nbits-1:0] size,
    input  logic [p_addr_nbits-1:0] base_addr,
    input  logic [1:0]              mode,
    output logic                    busy,
    output logic                    done,
    output logic [p_data_nbits-1:0] result,
    vec_reduce_xcel_if.master       mem
);

    state_t                  state_q, state_d;
    logic [p_addr_nbits-1:0] addr_q, addr_d;
    logic [p_size_nbits-1:0] count_q, count_d;
    logic [p_size_nbits-1:0] size_q, size_d;
    mode_t                   mode_q, mode_d;
    logic [p_data_nbits-1:0] result_q, result_d;

    mode_t                   alu_mode;
    logic [p_data_nbits-1:0] alu_out;
    logic [p_data_nbits-1:0] alu_ident;
    logic [p_size_nbits-1:0] count_inc;
    logic [p_addr_nbits-1:0] addr_inc;
    logic                    go_accept;
    logic                    resp_fire;
    logic                    last_elem;

    // In IDLE the ALU sees the incoming mode so the identity is ready on go.
    assign alu_mode  = (state_q == IDLE) ? mode_t'(mode) : mode_q;
    assign count_inc = count_q + 1'b1;
    assign addr_inc  = addr_q + p_addr_nbits'(c_word_bytes);
    assign go_accept = (state_q == IDLE) && go;
    assign resp_fire = (state_q == WAIT) && mem.memresp_val;
    assign last_elem = (count_inc == size_q);

    vec_reduce_alu #(.p_data_nbits(p_data_nbits)) u_alu (
        .mode     (alu_mode),
        .a        (result_q),
        .b        (mem.memresp_data),
        .out      (alu_out),
        .identity (alu_ident)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (go)              state_d = (size == '0) ? DONE : REQ;
            REQ:  if (mem.memreq_rdy)  state_d = WAIT;
            WAIT: if (mem.memresp_val) state_d = last_elem ? DONE : REQ;
            DONE:                      state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Datapath registers: address, count, latched operands and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            count_q  <= '0;
            size_q   <= '0;
            mode_q   <= SUM;
            result_q <= '0;
        end else begin
            addr_q   <= addr_d;
            count_q  <= count_d;
            size_q   <= size_d;
            mode_q   <= mode_d;
            result_q <= result_d;
        end
    end

    // Datapath next values: load on accepted go, advance on each response.
    always_comb begin
        addr_d   = addr_q;
        count_d  = count_q;
        size_d   = size_q;
        mode_d   = mode_q;
        result_d = result_q;
        if (go_accept) begin
            addr_d   = base_addr;
            count_d  = '0;
            size_d   = size;
            mode_d   = mode_t'(mode);
            result_d = alu_ident;
        end else if (resp_fire) begin
            addr_d   = addr_inc;
            count_d  = count_inc;
            result_d = alu_out;
        end
    end

    // Moore outputs decoded from the state.
    always_comb begin
        busy            = (state_q != IDLE);
        done            = (state_q == DONE);
        mem.memreq_val  = (state_q == REQ);
        mem.memreq_addr = addr_q;
        result          = result_q;
    end

endmodule

// File: tb/tb_vec_reduce_xcel.sv
// Bench for vec_reduce_xcel: memory model with configurable stalls, a
// scoreboard of expected addresses/results, and a monitor that checks them.
module tb_vec_reduce_xcel;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 14;

    typedef struct {
        logic [DW-1:0] res;
        int            done_cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          go;
    logic [SW-1:0] size;
    logic [AW-1:0] base_addr;
    logic [1:0]    mode;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;

    vec_reduce_xcel_if #(.p_addr_nbits(AW), .p_data_nbits(DW)) mem_if ();

    vec_reduce_xcel #(
        .p_data_nbits (DW),
        .p_addr_nbits (AW),
        .p_size_nbits (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .size      (size),
        .base_addr (base_addr),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .mem       (mem_if)
    );

    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            req_stall = 0;
    int            resp_delay = 0;
    bit            spur_en = 0;
    exp_t          exp_res_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] op_data[$];
    logic [DW-1:0] mem_model [logic [AW-1:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference reduction from the mode's definition.
    function automatic logic [DW-1:0] ref_reduce(input logic [1:0] m, input logic [DW-1:0] d[$]);
        longint acc;
        longint v;
        case (m)
            2'd0: begin
                acc = 0;
                foreach (d[i]) acc = acc + longint'(d[i]);
            end
            2'd1: begin
                acc = -(longint'(1) << (DW-1));
                foreach (d[i]) begin
                    v = longint'($signed(d[i]));
                    if (v > acc) acc = v;
                end
            end
            2'd2: begin
                acc = (longint'(1) << (DW-1)) - 1;
                foreach (d[i]) begin
                    v = longint'($signed(d[i]));
                    if (v < acc) acc = v;
                end
            end
            default: begin
                acc = 0;
                foreach (d[i]) acc = acc ^ longint'(d[i]);
            end
        endcase
        return acc[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return DW'($urandom);
        endcase
    endfunction

    // Memory model: stalls requests, delays responses, optionally injects
    // memresp_val outside WAIT.
    initial begin
        int            stall;
        int            dly;
        bit            pending;
        logic [AW-1:0] paddr;
        stall = 0; dly = 0; pending = 0; paddr = '0;
        mem_if.memreq_rdy = 1'b0;
        mem_if.memresp_val = 1'b0;
        mem_if.memresp_data = '0;
        forever begin
            @(negedge clk);
            mem_if.memreq_rdy = 1'b0;
            mem_if.memresp_val = 1'b0;
            mem_if.memresp_data = DW'($urandom);
            if (rst) begin
                pending = 0;
                stall = 0;
            end else if (pending) begin
                if (dly == 0) begin
                    mem_if.memresp_val = 1'b1;
                    mem_if.memresp_data = mem_model.exists(paddr) ? mem_model[paddr] : 32'hBAD0_BAD0;
                    pending = 0;
                end else begin
                    dly--;
                end
            end else if (mem_if.memreq_val) begin
                if (stall < req_stall) begin
                    stall++;
                    mem_if.memresp_val = spur_en;
                end else begin
                    mem_if.memreq_rdy = 1'b1;
                    stall = 0;
                    pending = 1;
                    dly = resp_delay;
                    paddr = mem_if.memreq_addr;
                end
            end else if (spur_en) begin
                mem_if.memresp_val = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: checks request addresses and the result/timing at done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (mem_if.memreq_val) begin
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected_req", 64'(mem_if.memreq_val), 64'(0));
                    end else begin
                        check(mem_if.memreq_rdy ? "req_addr" : "stalled_addr",
                              64'(mem_if.memreq_addr), 64'(exp_addr_q[0]));
                        if (mem_if.memreq_rdy) void'(exp_addr_q.pop_front());
                    end
                end
                if (done) begin
                    if (exp_res_q.size() == 0) begin
                        check("unexpected_done", 64'(done), 64'(0));
                    end else begin
                        e = exp_res_q.pop_front();
                        check("result", 64'(result), 64'(e.res));
                        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                        check("busy_in_done", 64'(busy), 64'(1));
                    end
                end
            end
        end
    end

    // Issue one operation over op_data and wait for its done cycle.
    // chain=1: caller is in a DONE cycle and go is held through it.
    task automatic run_op(input logic [1:0] m, input logic [AW-1:0] base, input int rs,
                          input int rd, input bit spur, input bit chain, input bit go_mid,
                          output logic [DW-1:0] fin);
        int            n;
        int            budget;
        bit            seen;
        logic [AW-1:0] a;
        exp_t          e;
        n = op_data.size();
        req_stall = rs;
        resp_delay = rd;
        spur_en = spur;
        a = base;
        foreach (op_data[i]) begin
            mem_model[a] = op_data[i];
            a = a + AW'(4);
        end
        fin = ref_reduce(m, op_data);
        mode = m;
        size = SW'(n);
        base_addr = base;
        go = 1'b1;
        if (chain) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        size = SW'($urandom);
        base_addr = AW'($urandom);
        mode = 2'($urandom);
        e.res = fin;
        e.done_cyc = cyc + n * (rs + rd + 2);
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(a);
            a = a + AW'(4);
        end
        exp_res_q.push_back(e);
        budget = 20 + n * (rs + rd + 2);
        seen = (done === 1'b1);
        for (int i = 1; i <= budget && !seen; i++) begin
            @(negedge clk);
            seen = (done === 1'b1);
            if (!seen) begin
                if (go_mid && i == 1) begin
                    go = 1'b1;
                    size = SW'($urandom);
                    base_addr = AW'($urandom);
                    mode = 2'($urandom);
                end
                if (i == 3) go = 1'b0;
            end
        end
        if (!seen) begin
            check("done_timeout", 64'(done), 64'(1));
            go = 1'b0;
            exp_res_q.delete();
            exp_addr_q.delete();
        end
    endtask

    // One cycle after done: back in IDLE with the result held.
    task automatic after_op(input logic [DW-1:0] fin);
        @(negedge clk);
        check("result_hold", 64'(result), 64'(fin));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_done", 64'(done), 64'(0));
    endtask

    // Start a SUM, reset it while in WAIT, and check the aborted state.
    task automatic abort_op();
        logic [AW-1:0] a;
        op_data = '{32'd10, 32'd20, 32'd30};
        req_stall = 0;
        resp_delay = 5;
        spur_en = 0;
        a = 16'h0040;
        foreach (op_data[i]) begin
            mem_model[a] = op_data[i];
            a = a + AW'(4);
        end
        mode = 2'd0;
        size = SW'(3);
        base_addr = 16'h0040;
        go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        a = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back(a);
            a = a + AW'(4);
        end
        @(negedge clk);
        check("abort_wait_busy", 64'(busy), 64'(1));
        check("abort_wait_noreq", 64'(mem_if.memreq_val), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_addr_q.delete();
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_result", 64'(result), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_req_val", 64'(mem_if.memreq_val), 64'(0));
        check("abort_req_addr", 64'(mem_if.memreq_addr), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] fin;
        logic [1:0]    m;
        int            n;
        bit            chain;
        rst = 1'b1;
        go = 1'b0;
        size = '0;
        base_addr = '0;
        mode = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_req_val", 64'(mem_if.memreq_val), 64'(0));
        check("rst_req_addr", 64'(mem_if.memreq_addr), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        op_data = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_op(2'd0, 16'h0100, 0, 0, 0, 0, 0, fin);
        after_op(fin);

        op_data = '{32'd5, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000};
        run_op(2'd1, 16'h0300, 0, 0, 0, 0, 0, fin);
        after_op(fin);
        run_op(2'd2, 16'h0300, 0, 0, 0, 0, 0, fin);
        after_op(fin);

        op_data = '{32'h0000_F0F0, 32'h0000_0FF0};
        run_op(2'd3, 16'h0400, 0, 0, 0, 0, 0, fin);
        after_op(fin);

        op_data.delete();
        for (int i = 0; i < 4; i++) begin
            run_op(2'(i), 16'h0500, 0, 0, 0, 0, 0, fin);
            after_op(fin);
        end

        op_data = '{32'h1234_5678, 32'h0000_0011};
        run_op(2'd0, 16'h0200, 3, 2, 1, 0, 0, fin);
        after_op(fin);

        op_data = '{32'hFFFF_FFFF, 32'd2};
        run_op(2'd0, 16'hFFFC, 0, 0, 0, 0, 0, fin);
        after_op(fin);

        abort_op();
        op_data = '{32'd7};
        run_op(2'd0, 16'h0600, 0, 0, 0, 0, 0, fin);
        after_op(fin);

        op_data = '{32'd9, 32'hFFFF_FFF0, 32'd3};
        run_op(2'd1, 16'h0700, 1, 1, 0, 0, 1, fin);
        op_data = '{32'hAAAA_0000, 32'h0000_5555};
        run_op(2'd3, 16'h0800, 0, 0, 0, 1, 0, fin);
        after_op(fin);

        chain = 0;
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(0, 6);
            m = 2'($urandom);
            op_data.delete();
            for (int k = 0; k < n; k++) op_data.push_back(rand_word());
            run_op(m, AW'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), chain, (n >= 2) && ($urandom_range(0, 1) == 1), fin);
            chain = ($urandom_range(0, 2) == 0);
            if (!chain) after_op(fin);
        end

        repeat (5) @(negedge clk);
        check("pending_results", 64'(exp_res_q.size()), 64'(0));
        check("pending_addrs", 64'(exp_addr_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
